// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe
//   Two-stage pipelined modular adder/subtractor for the shared NTT datapath.
//   Each operation is one of:
//     - two independent Kyber lanes packed as {hi, lo}, reduced mod KQ
//     - one full-width Dilithium word, reduced mod DQ
//   Stage 1 registers the raw sum, or the difference plus its borrow bit.
//   Stage 2 applies a single conditional correction by q.
//   Both stages advance together whenever the output is empty or being taken.
//
// Optional feature macro: MOD_ADDSUB_RANGE_CHK_EN
//   defined   -> out_err flags any operand (lane) >= its modulus; the flag
//                travels with its operation through the pipe
//   undefined -> out_err is tied to 0
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   block accepts operands this cycle (combinational)
//   mode       00 Kyber add, 01 Kyber sub, 10 Dilithium add, 11 Dilithium sub
//   a, b       operands, W = 2*LANE_W bits; Kyber modes pack {hi lane, lo lane}
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        modular result, packed the same way as the operands
//   out_err    operand range flag

module mod_addsub_pipe #(
    parameter int LANE_W = 12,
    parameter int KQ     = 3329,
    parameter int DQ     = 8380417
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            mode,
    input  logic [2*LANE_W-1:0]   a,
    input  logic [2*LANE_W-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*LANE_W-1:0]   sum,
    output logic                  out_err
);

    localparam int W = 2 * LANE_W;

    // Moduli widened by one bit so they compare directly against raw sums.
    localparam logic [LANE_W:0] C_KQ_X = (LANE_W + 1)'(KQ);
    localparam logic [W:0]      C_DQ_X = (W + 1)'(DQ);

    logic              w_en;
    logic [LANE_W-1:0] w_a_lo, w_a_hi, w_b_lo, w_b_hi;
    logic [LANE_W:0]   w_k_lo, w_k_hi;
    logic [W:0]        w_d;
    logic [W-1:0]      w_corr;

    logic              r_s1_valid;
    logic [1:0]        r_s1_mode;
    logic [LANE_W:0]   r_s1_klo;
    logic [LANE_W:0]   r_s1_khi;
    logic [W:0]        r_s1_dw;
    logic              r_out_valid;
    logic [W-1:0]      r_sum;

    assign w_en      = ~r_out_valid | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;

    assign w_a_lo = a[LANE_W-1:0];
    assign w_a_hi = a[W-1:LANE_W];
    assign w_b_lo = b[LANE_W-1:0];
    assign w_b_hi = b[W-1:LANE_W];

    // Stage 1 raw results. The extra MSB is the carry on add, or the
    // borrow on sub. The Kyber lanes are built separately, so no carry or
    // borrow can cross the lane boundary.
    assign w_k_lo = mode[0] ? ({1'b0, w_a_lo} - {1'b0, w_b_lo})
                            : ({1'b0, w_a_lo} + {1'b0, w_b_lo});
    assign w_k_hi = mode[0] ? ({1'b0, w_a_hi} - {1'b0, w_b_hi})
                            : ({1'b0, w_a_hi} + {1'b0, w_b_hi});
    assign w_d    = mode[0] ? ({1'b0, a} - {1'b0, b})
                            : ({1'b0, a} + {1'b0, b});

    function automatic logic [LANE_W-1:0] fix_lane(input logic [LANE_W:0] raw,
                                                   input logic is_sub);
        logic [LANE_W:0] t;
        t = raw - C_KQ_X;
        if (is_sub)
            return raw[LANE_W] ? raw[LANE_W-1:0] + C_KQ_X[LANE_W-1:0]
                               : raw[LANE_W-1:0];
        else
            return (raw >= C_KQ_X) ? t[LANE_W-1:0] : raw[LANE_W-1:0];
    endfunction

    function automatic logic [W-1:0] fix_word(input logic [W:0] raw,
                                              input logic is_sub);
        logic [W:0] t;
        t = raw - C_DQ_X;
        if (is_sub)
            return raw[W] ? raw[W-1:0] + C_DQ_X[W-1:0] : raw[W-1:0];
        else
            return (raw >= C_DQ_X) ? t[W-1:0] : raw[W-1:0];
    endfunction

    assign w_corr = r_s1_mode[1] ? fix_word(r_s1_dw, r_s1_mode[0])
                                 : {fix_lane(r_s1_khi, r_s1_mode[0]),
                                    fix_lane(r_s1_klo, r_s1_mode[0])};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= '0;
            r_s1_klo    <= '0;
            r_s1_khi    <= '0;
            r_s1_dw     <= '0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            r_out_valid <= r_s1_valid;
            if (in_valid) begin
                r_s1_mode <= mode;
                r_s1_klo  <= w_k_lo;
                r_s1_khi  <= w_k_hi;
                r_s1_dw   <= w_d;
            end
            // A bubble leaves the previous sum in place; only valid results load it.
            if (r_s1_valid)
                r_sum <= w_corr;
        end
    end

`ifdef MOD_ADDSUB_RANGE_CHK_EN
    localparam logic [LANE_W-1:0] C_KQ = (LANE_W)'(KQ);
    localparam logic [W-1:0]      C_DQ = (W)'(DQ);

    logic w_err;
    logic r_s1_err;
    logic r_err;

    assign w_err = mode[1] ? ((a >= C_DQ) || (b >= C_DQ))
                           : ((w_a_lo >= C_KQ) || (w_a_hi >= C_KQ) ||
                              (w_b_lo >= C_KQ) || (w_b_hi >= C_KQ));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_err <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_en) begin
            if (in_valid)
                r_s1_err <= w_err;
            if (r_s1_valid)
                r_err <= r_s1_err;
        end
    end

    assign out_err = r_err;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
module tb_mod_addsub_pipe;

    localparam int KQ = 3329;
    localparam int DQ = 8380417;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [23:0] a;
    logic [23:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] sum;
    logic        out_err;

    mod_addsub_pipe #(.LANE_W(12), .KQ(KQ), .DQ(DQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] sum;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_stall = -1;
    logic        prev_stall = 1'b0;
    logic [23:0] prev_sum = '0;
    logic        prev_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain modular arithmetic, returns {err, sum}.
    function automatic logic [24:0] model(input logic [1:0] m, input logic [23:0] av,
                                          input logic [23:0] bv);
        int          x, y, r;
        logic [23:0] s;
        logic        e;
        s = '0;
        e = 1'b0;
        if (m[1]) begin
            x = int'(av);
            y = int'(bv);
            r = m[0] ? x - y : x + y;
            if (!m[0] && r >= DQ) r = r - DQ;
            if (m[0] && r < 0)    r = r + DQ;
            s = r[23:0];
            e = (x >= DQ) || (y >= DQ);
        end else begin
            for (int l = 0; l < 2; l++) begin
                x = int'(av[12*l +: 12]);
                y = int'(bv[12*l +: 12]);
                r = m[0] ? x - y : x + y;
                if (!m[0] && r >= KQ) r = r - KQ;
                if (m[0] && r < 0)    r = r + KQ;
                s[12*l +: 12] = r[11:0];
                e = e | (x >= KQ) | (y >= KQ);
            end
        end
`ifndef MOD_ADDSUB_RANGE_CHK_EN
        e = 1'b0;
`endif
        return {e, s};
    endfunction

    // One clock cycle: drive at the falling edge, check, then account for
    // the transfers that happen at the following rising edge.
    task automatic cycle(input logic v, input logic [1:0] m, input logic [23:0] av,
                         input logic [23:0] bv, input logic ordy,
                         input logic use_exp, input logic [24:0] exp_v,
                         output logic acc);
        exp_t e;
        logic [24:0] mv;
        @(negedge clk);
        in_valid  = v;
        mode      = m;
        a         = av;
        b         = bv;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, !out_valid || ordy);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_sum", sum, prev_sum);
            chk("stall_err", out_err, prev_err);
        end
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("extra_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", sum, e.sum);
                chk("out_err", out_err, e.err);
                if (last_stall < e.cyc)
                    chk("latency", cyc - e.cyc, 2);
            end
        end
        if (out_valid && !ordy) last_stall = cyc;
        prev_stall = out_valid && !ordy;
        prev_sum   = sum;
        prev_err   = out_err;
        acc = v && in_ready;
        if (acc) begin
            mv = use_exp ? exp_v : model(m, av, bv);
            e.sum = mv[23:0];
            e.err = mv[24];
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        cyc++;
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cycle(1'b0, 2'b00, '0, '0, 1'b1, 1'b0, '0, acc);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    logic        acc;
    logic [24:0] e00, e10;
    logic [1:0]  sm[6];
    logic [23:0] sa[6];
    logic [23:0] sb[6];

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = '0; a = '0; b = '0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_out_err", out_err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Kyber add, isolated, with latency check
        cycle(1'b1, 2'b00, {12'd3000, 12'd100}, {12'd500, 12'd200}, 1'b1, 1'b1,
              {1'b0, 12'd171, 12'd300}, acc);
        drain();

        // Kyber sub, lanes independent
        cycle(1'b1, 2'b01, {12'd5, 12'd3328}, {12'd10, 12'd1}, 1'b1, 1'b1,
              {1'b0, 12'd3324, 12'd3327}, acc);
        drain();

        // Dilithium add then sub, back to back
        cycle(1'b1, 2'b10, 24'd8380416, 24'd1, 1'b1, 1'b1, {1'b0, 24'd0}, acc);
        cycle(1'b1, 2'b11, 24'd0, 24'd1, 1'b1, 1'b1, {1'b0, 24'd8380416}, acc);
        drain();

        // Six-op stream with a three-cycle output stall in the middle
        for (int i = 0; i < 6; i++) begin
            sm[i] = 2'($urandom_range(0, 3));
            sa[i] = sm[i][1] ? 24'($urandom_range(0, DQ - 1))
                             : {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
            sb[i] = sm[i][1] ? 24'($urandom_range(0, DQ - 1))
                             : {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
        end
        begin
            int idx, c;
            idx = 0; c = 0;
            while (idx < 6 && c < 40) begin
                cycle(1'b1, sm[idx], sa[idx], sb[idx], !(c >= 3 && c < 6), 1'b0, '0, acc);
                if (acc) idx++;
                c++;
            end
            if (idx != 6) chk("stream_timeout", idx, 6);
        end
        drain();

        // Range flag vectors
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        e00 = {1'b1, 24'd0};
`else
        e00 = {1'b0, 24'd0};
`endif
        e10 = {1'b0, 24'd8380416};
        cycle(1'b1, 2'b00, {12'd3329, 12'd0}, 24'd0, 1'b1, 1'b1, e00, acc);
        cycle(1'b1, 2'b10, 24'd8380416, 24'd0, 1'b1, 1'b1, e10, acc);
        drain();

        // Reset with two operations in flight
        cycle(1'b1, 2'b00, {12'd1, 12'd2}, {12'd3, 12'd4}, 1'b1, 1'b0, '0, acc);
        cycle(1'b1, 2'b10, 24'd100, 24'd200, 1'b1, 1'b0, '0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_out_err", out_err, 0);
        exp_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 2'b01, {12'd7, 12'd0}, {12'd9, 12'd1}, 1'b1, 1'b1,
              {1'b0, 12'd3327, 12'd3328}, acc);
        drain();

        // Randomized traffic with random backpressure and bubbles
        for (int i = 0; i < 300; i++) begin
            logic [1:0]  m;
            logic [23:0] av, bv;
            m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                av = 24'($urandom);
                bv = 24'($urandom);
            end else if (m[1]) begin
                av = 24'($urandom_range(0, DQ - 1));
                bv = 24'($urandom_range(0, DQ - 1));
            end else begin
                av = {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
                bv = {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
            end
            cycle($urandom_range(0, 3) != 0, m, av, bv, $urandom_range(0, 3) != 0,
                  1'b0, '0, acc);
            // hold operands while not accepted, as upstream must
            while (in_valid && !acc && i < 300) begin
                cycle(1'b1, m, av, bv, $urandom_range(0, 3) != 0, 1'b0, '0, acc);
                i++;
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
- Pipelined modular adder/subtractor for the shared NTT datapath.
- Handles two lane-packed Kyber lanes (mod KQ) or one full-width Dilithium word (mod DQ).
- Supports both add and subtract in each modulus.
- Two-stage registered pipeline with valid/ready handshake and backpressure; feeds butterfly and accumulate paths.

Parameters:
- LANE_W, 12, width of one Kyber lane; full word width W = 2*LANE_W.
- KQ, 3329, Kyber modulus; must be < 2^LANE_W.
- DQ, 8380417, Dilithium modulus; must be < 2^W.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block accepts operands this cycle
- mode  input  2  00 Kyber lane add; 01 Kyber lane sub; 10 Dilithium add; 11 Dilithium sub
- a  input  W  operand A; in Kyber modes {hi lane, lo lane}
- b  input  W  operand B; same packing as a
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  W  modular result; same packing as inputs
- out_err  output  1  operand range flag (see Optional Feature)

Behaviour:
- Reset: clk single clock domain; rst asynchronous, active-high.
  - All pipeline valids clear to 0; out_valid=0, sum=0, out_err=0.
  - in_ready=1 while rst is low and the pipe is empty.
- Advance enable: en = ~out_valid | out_ready.
  - in_ready = en, combinational.
  - Both stages advance only when en=1. With en=0, every stage register holds, including data, mode and valid.
- Transfer rules:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - Latency is exactly 2 cycles from input transfer to out_valid, when unstalled.
  - Throughput is one operation per cycle.
  - A bubble (in_valid=0 with en=1) propagates as valid=0.
- Stage 1 (registered), raw operation:
  - Kyber modes: per lane, add gives an (LANE_W+1)-bit sum; sub gives a difference plus a borrow bit.
  - Dilithium modes: add gives a (W+1)-bit sum; sub gives a W-bit difference plus a borrow bit.
  - Kyber lanes are fully independent: no carry or borrow crosses the lane boundary.
  - Stage 1 also registers mode.
- Stage 2 (registered), correction, with q = KQ per lane or DQ:
  - Add: r = s - q if s >= q, else r = s.
  - Sub: r = d + q if borrow, else r = d (taken modulo 2^LANE_W or 2^W).
  - For inputs < q, the result is always in [0, q-1].
  - Inputs >= q still produce this deterministic formula, truncated to lane or word width.
- Mode is sampled per operation. Back-to-back operations with different modes must each use their own mode; no flush is needed.
- Stall behaviour:
  - While out_valid=1 and out_ready=0, sum and out_valid hold stable and in_ready=0.
  - Upstream must hold a and b, since no transfer occurs.
- Simultaneous events: out_ready rising in the same cycle as in_valid lets the output retire and the new input enter together. No operation is lost or duplicated.
- Reset mid-operation: in-flight operations are discarded; the first valid output after reset belongs to the first operation accepted after reset.

Optional Feature:
- Macro: MOD_ADDSUB_RANGE_CHK_EN.
- Defined:
  - Stage 1 computes err = any operand lane >= KQ (Kyber modes) or a >= DQ or b >= DQ (Dilithium modes).
  - err travels with its operation; out_err is valid with out_valid and holds during stalls.
- Undefined: out_err is tied to 0 and no comparator logic is generated.

Test Plan:
- Mode 00, a={3000,100}, b={500,200} -> after 2 cycles sum={171,300}, out_err=0.
- Mode 01, a={5,3328}, b={10,1} -> sum={3324,3327}; lanes independent, no cross-lane borrow.
- Mode 10, a=8380416, b=1 -> sum=0; mode 11, a=0, b=1 -> sum=8380416; issued back-to-back, two consecutive outputs in order.
- Stream 6 operations with in_valid=1 continuously and out_ready low for 3 cycles mid-stream:
  - in_ready drops with the stall.
  - sum holds stable during the stall.
  - All 6 results emerge in order, none lost or duplicated.
- Assert rst for 1 cycle with 2 operations in flight -> out_valid=0 and sum=0 immediately (asynchronous). Next accepted operation appears 2 cycles later.
- With MOD_ADDSUB_RANGE_CHK_EN, mode 00, a={3329,0}, b=0 -> out_err=1. Mode 10, a=8380416, b=0 -> out_err=0. Without the macro, out_err=0 for both.
